// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN consecutive unsigned products from the array
// multiplier into a W-bit result. The sum wraps modulo 2^W, and a sticky flag
// records whether it wrapped. The finished sum sits in an output register with
// a valid/ready handshake. While that register is occupied and not draining,
// the block stalls the product stream.
module product_accumulator #(
  parameter int n   = 4,
  parameter int W   = 2*n+4,
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [2*n-1:0] prod,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           clear,
  output logic [W-1:0]   sum,
  output logic           ovf,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int            CW      = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(LEN-1);

  logic [W-1:0]  accQ, accD;
  logic          aovfQ, aovfD;
  logic [CW-1:0] cntQ, cntD;
  logic [W-1:0]  sumQ, sumD;
  logic          ovfQ, ovfD;
  logic          outValidQ, outValidD;

  logic          accept;
  logic          lastTerm;
  logic [W:0]    prodExt;
  logic [W:0]    addFull;

  // A term can enter whenever the result slot is empty or is being emptied
  // this cycle. The slot drains and refills on the same edge, so no bubble
  // appears between groups. clear blocks acceptance while it aborts.
  assign in_ready = !clear && (!outValidQ || out_ready);
  assign accept   = in_valid && in_ready;
  assign lastTerm = (cntQ == LastCnt);

  // The extra top bit of the sum is the carry-out of the W-bit add. That bit
  // feeds the sticky wrap flag.
  assign prodExt = {{(W+1-2*n){1'b0}}, prod};
  assign addFull = {1'b0, accQ} + prodExt;

  // Next-state: the output drain, the clear, and the term acceptance are
  // resolved here. A last-term load overrides the drain so the new result
  // replaces the one leaving.
  always_comb begin
    accD      = accQ;
    aovfD     = aovfQ;
    cntD      = cntQ;
    sumD      = sumQ;
    ovfD      = ovfQ;
    outValidD = outValidQ;

    if (outValidQ && out_ready) begin
      outValidD = 1'b0;
    end

    if (clear) begin
      accD  = '0;
      aovfD = 1'b0;
      cntD  = '0;
    end else if (accept) begin
      if (lastTerm) begin
        sumD      = addFull[W-1:0];
        ovfD      = aovfQ | addFull[W];
        outValidD = 1'b1;
        accD      = '0;
        aovfD     = 1'b0;
        cntD      = '0;
      end else begin
        accD  = addFull[W-1:0];
        aovfD = aovfQ | addFull[W];
        cntD  = cntQ + 1'b1;
      end
    end
  end

  // State register. Reset is asynchronous and discards the partial group and
  // any pending result.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      accQ      <= '0;
      aovfQ     <= 1'b0;
      cntQ      <= '0;
      sumQ      <= '0;
      ovfQ      <= 1'b0;
      outValidQ <= 1'b0;
    end else begin
      accQ      <= accD;
      aovfQ     <= aovfD;
      cntQ      <= cntD;
      sumQ      <= sumD;
      ovfQ      <= ovfD;
      outValidQ <= outValidD;
    end
  end

  assign sum       = sumQ;
  assign ovf       = ovfQ;
  assign out_valid = outValidQ;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator. Three instances share one input stream:
//   A: n=4, W=12, LEN=4
//   B: n=4, W=9,  LEN=4 (wraps on large groups)
//   C: n=4, W=12, LEN=1 (every term is a result)
// The reference model keeps exact integer group sums and queues the finished
// results. The monitor compares each DUT against the modulo-2^W value of the
// queued sum.
module tb_product_accumulator;

  localparam longint ModA = 64'd4096;
  localparam longint ModB = 64'd512;
  localparam longint ModC = 64'd4096;
  localparam int     Len  = 4;

  logic        clk;
  logic        nReset;
  logic [7:0]  prod;
  logic        inValid;
  logic        clr;
  logic        outReady;

  logic        inReadyA, inReadyB, inReadyC;
  logic [11:0] sumA;
  logic [8:0]  sumB;
  logic [11:0] sumC;
  logic        ovfA, ovfB, ovfC;
  logic        outValidA, outValidB, outValidC;

  int          checks;
  int          failures;

  // The A and B instances accept identical terms, so they share one queue of
  // exact sums. C gets its own queue because its acceptance pattern differs.
  longint      qAB[$];
  longint      qC[$];
  longint      grpSum;
  int          grpCnt;
  longint      lastAB;
  longint      lastC;
  longint      curAB;
  longint      curC;
  bit          fullAB;
  bit          fullC;
  bit          expRdyAB;
  bit          expRdyC;

  product_accumulator #(.n(4), .W(12), .LEN(4)) dutA (
    .clk(clk), .n_reset(nReset), .prod(prod), .in_valid(inValid),
    .in_ready(inReadyA), .clear(clr), .sum(sumA), .ovf(ovfA),
    .out_valid(outValidA), .out_ready(outReady)
  );

  product_accumulator #(.n(4), .W(9), .LEN(4)) dutB (
    .clk(clk), .n_reset(nReset), .prod(prod), .in_valid(inValid),
    .in_ready(inReadyB), .clear(clr), .sum(sumB), .ovf(ovfB),
    .out_valid(outValidB), .out_ready(outReady)
  );

  product_accumulator #(.n(4), .W(12), .LEN(1)) dutC (
    .clk(clk), .n_reset(nReset), .prod(prod), .in_valid(inValid),
    .in_ready(inReadyC), .clear(clr), .sum(sumC), .ovf(ovfC),
    .out_valid(outValidC), .out_ready(outReady)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the edge that
  // consumed them.
  task automatic applyStimulus(input logic [7:0] p, input logic v, input logic c, input logic r);
    prod     = p;
    inValid  = v;
    clr      = c;
    outReady = r;
    @(posedge clk);
    #1;
  endtask

  // Issues a whole group of identical terms.
  task automatic applyGroup(input logic [7:0] p, input int count, input logic r);
    for (int i = 0; i < count; i++) applyStimulus(p, 1'b1, 1'b0, r);
  endtask

  // Monitor and model. Inputs are stable from just after a rising edge
  // through the next one, so at the falling edge this block compares the DUT
  // outputs with the model. It then advances the model by what the coming
  // rising edge will do.
  always @(negedge clk) begin
    if (!nReset) begin
      qAB.delete();
      qC.delete();
      grpSum = 0;
      grpCnt = 0;
      lastAB = 0;
      lastC  = 0;
    end

    fullAB   = (qAB.size() != 0);
    fullC    = (qC.size() != 0);
    expRdyAB = !clr && (!fullAB || outReady);
    expRdyC  = !clr && (!fullC || outReady);
    curAB    = fullAB ? qAB[0] : lastAB;
    curC     = fullC ? qC[0] : lastC;

    checkOutput("in_ready_A", inReadyA, expRdyAB);
    checkOutput("in_ready_B", inReadyB, expRdyAB);
    checkOutput("in_ready_C", inReadyC, expRdyC);
    checkOutput("out_valid_A", outValidA, fullAB);
    checkOutput("out_valid_B", outValidB, fullAB);
    checkOutput("out_valid_C", outValidC, fullC);
    checkOutput("sum_A", sumA, curAB % ModA);
    checkOutput("sum_B", sumB, curAB % ModB);
    checkOutput("sum_C", sumC, curC % ModC);
    checkOutput("ovf_A", ovfA, curAB >= ModA);
    checkOutput("ovf_B", ovfB, curAB >= ModB);
    checkOutput("ovf_C", ovfC, curC >= ModC);

    if (nReset) begin
      if (fullAB && outReady) lastAB = qAB.pop_front();
      if (fullC && outReady)  lastC  = qC.pop_front();

      if (clr) begin
        grpSum = 0;
        grpCnt = 0;
      end else if (inValid && expRdyAB) begin
        grpSum += longint'(prod);
        grpCnt++;
        if (grpCnt == Len) begin
          qAB.push_back(grpSum);
          grpSum = 0;
          grpCnt = 0;
        end
      end

      if (inValid && expRdyC) qC.push_back(longint'(prod));
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    checks   = 0;
    failures = 0;
    nReset   = 1'b0;
    prod     = '0;
    inValid  = 1'b0;
    clr      = 1'b0;
    outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nReset = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);

    // Basic sum 900 (B wraps to 388 with ovf), then a group of ones to show
    // the wrap flag does not stick across groups.
    applyGroup(8'd225, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    applyGroup(8'd1, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);

    // Backpressure: the result stays pending for 5 cycles with in_valid high.
    // A one-cycle release then lets the next group of tens start with no gap.
    applyGroup(8'd225, 4, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'd7, 1'b1, 1'b0, 1'b0);
    applyGroup(8'd10, 4, 1'b1);
    applyGroup(8'd10, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);

    // A pending result survives clear. A partial group is discarded by it.
    applyGroup(8'd3, 4, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    applyGroup(8'd225, 2, 1'b1);
    applyStimulus(8'd225, 1'b1, 1'b1, 1'b1);
    applyGroup(8'd1, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);

    // Async reset between edges, in the middle of a group, with an old
    // result still visible on sum.
    applyGroup(8'd5, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    applyGroup(8'd225, 2, 1'b1);
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("reset_out_valid_A", outValidA, 0);
    checkOutput("reset_sum_A", sumA, 0);
    checkOutput("reset_sum_B", sumB, 0);
    checkOutput("reset_sum_C", sumC, 0);
    checkOutput("reset_ovf_A", ovfA, 0);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    nReset = 1'b1;
    applyGroup(8'd3, 4, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic: the products come from 4x4 operands. Valid,
    // ready and clear are random.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(8'($urandom_range(0, 15) * $urandom_range(0, 15)),
                    1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 29) == 0),
                    1'($urandom_range(0, 9) < 6));
    end

    // Drain everything and confirm no expected result was left undelivered.
    repeat (3) applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("drained_AB", qAB.size(), 0);
    checkOutput("drained_C", qC.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Unsigned accumulator that consumes the 2n-bit products of the combinational array multiplier and sums a fixed number of consecutive products (dot-product style) into one result. It sits directly downstream of the multiplier, registers the finished sum, and presents it with a valid/ready handshake. Both its input and output ports use valid/ready, so it stalls the product stream when the result register is occupied.

## Interface

- n, 4, multiplier operand width; the product input is 2n bits
- W, 2n+4, accumulator and result width in bits; must be at least 2n
- LEN, 4, number of products summed per result; must be at least 1

- clk  in  1  rising-edge clock
- n_reset  in  1  asynchronous, active-low reset
- prod  in  2n  unsigned product from the multiplier
- in_valid  in  1  prod is valid this cycle
- in_ready  out  1  block accepts prod this cycle; a term is accepted when in_valid && in_ready
- clear  in  1  synchronous abort of the partial accumulation
- sum  out  W  registered result, modulo 2^W
- ovf  out  1  the result in sum wrapped at least once; qualified by out_valid
- out_valid  out  1  sum and ovf are valid
- out_ready  in  1  consumer takes sum when out_valid && out_ready

## Operation

- Internal state: acc[W-1:0], accumulated ovf flag aovf, term counter cnt (width max(1, clog2(LEN)), range 0..LEN-1), output register {sum, ovf, out_valid}.
- Two phases: ACCUM (cnt counts accepted terms) and output FULL/EMPTY (out_valid). These phases are independent.
- in_ready = !clear && (!out_valid || out_ready). This is combinational.
- Accepted term, not last (cnt < LEN-1): acc <= acc + prod (prod zero-extended, truncated to W); aovf <= aovf | carry-out; cnt <= cnt+1.
- Accepted term, last (cnt == LEN-1): sum <= acc + prod; ovf <= aovf | carry-out; out_valid <= 1; acc <= 0; aovf <= 0; cnt <= 0.
- LEN = 1: every accepted term is the last term, so sum = prod.
- Output drain: out_valid && out_ready && no last-term accept in the same cycle, so out_valid <= 0. sum and ovf keep their values.
- Simultaneous drain and last-term accept: out_valid stays 1 and sum/ovf load the new result. No bubble and no lost result.
- Output full and out_ready = 0: in_ready = 0. acc, cnt, sum and ovf hold. sum must stay stable while out_valid = 1 and out_ready = 0.
- clear = 1: acc <= 0, aovf <= 0, cnt <= 0. No term is accepted (in_ready = 0). The output register is unaffected, so a pending result still drains normally.
- Arithmetic is unsigned and wraps modulo 2^W. The carry-out of the W-bit add sets the sticky flag.

## Timing

- Reset (n_reset low, asynchronous): acc = 0, cnt = 0, aovf = 0, sum = 0, ovf = 0, out_valid = 0. in_ready = 1 once clear is low.
- Reset mid-accumulation or with a result pending discards everything. The first accepted term after reset starts a new group.
- Latency: out_valid rises on the clock edge that accepts the last term. The result is visible in the cycle after that acceptance.
- Throughput: one term per cycle whenever the output is empty or draining. With out_ready held high, each group of LEN terms takes exactly LEN accepting cycles.
- No combinational path from prod or in_valid to any output. in_ready depends combinationally only on clear, out_valid and out_ready.

## Test plan

- Basic sum: n=4, W=12, LEN=4, four accepted prod=225 back-to-back, out_ready=1 -> one cycle after the 4th accept: out_valid=1, sum=900, ovf=0.
- Overflow: W=9, same stimulus -> sum=388 (900 mod 512), ovf=1. The next group of four prod=1 gives sum=4, ovf=0, so the flag has cleared.
- Backpressure: a result is pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout and sum=900 is stable. out_ready=1 for one cycle -> drain, in_ready=1 in that same cycle.
- Drain plus last-term accept in the same cycle: out_valid stays 1 and sum switches directly to the next group's value (e.g. 4 × prod=10 gives 40), with no idle cycle.
- clear after 2 terms of 225, then four terms of prod=1 -> sum=4. A result already pending when clear is asserted is still delivered unchanged.
- Async reset asserted mid-group (between clock edges) -> all outputs 0 immediately. After release, four terms of prod=3 -> sum=12.
